// File: rtl/pif_bus_fabric.sv
`default_nettype none
// ============================================================================
// Module      : pif_bus_fabric
// Description : 6502 bus fabric. Decodes the address window, selects one
//               slave, muxes its data and ready, and applies a wait-state
//               watchdog with error capture.
// Revision    : 1.0 - initial release
// ============================================================================
module pif_bus_fabric #(
  parameter int                         NUM_SLAVES     = 8,
  parameter logic [NUM_SLAVES*16-1:0]   SLAVE_BASE     = {16'h0E00, 16'h0C00, 16'h0A00, 16'h0800,
                                                          16'h0600, 16'h0400, 16'h0200, 16'h0000},
  parameter logic [NUM_SLAVES*16-1:0]   SLAVE_MASK     = {NUM_SLAVES{16'hFE00}},
  parameter bit                         DEFAULT_EN     = 1'b1,
  parameter int                         DEFAULT_SLAVE  = 7,
  parameter int                         TIMEOUT_CYCLES = 255,
  parameter logic [7:0]                 FILL_BYTE      = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset_l,
  input  logic [15:0]              cpu_address,
  input  logic                     cpu_write,
  output logic [7:0]               cpu_data_in,
  output logic                     cpu_ready,
  output logic [NUM_SLAVES-1:0]    slave_oe,
  output logic [NUM_SLAVES-1:0]    slave_wr,
  input  logic [NUM_SLAVES-1:0]    slave_valid,
  input  logic [NUM_SLAVES*8-1:0]  slave_rdata,
  input  logic                     err_clear,
  output logic                     bus_err,
  output logic [15:0]              err_address,
  output logic                     err_is_timeout,
  output logic [7:0]               err_count
);

  localparam int                 c_idx_w   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [c_idx_w-1:0] c_def_idx = c_idx_w'(DEFAULT_SLAVE);
  localparam logic [15:0]        c_tmo     = 16'(TIMEOUT_CYCLES);
  localparam bit                 c_tmo_en  = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [15:0]          r_wcnt, w_wcnt_nxt;
  logic [15:0]          r_addr_q, w_addr_nxt;
  logic                 r_bus_err;
  logic [15:0]          r_err_address;
  logic                 r_err_is_timeout;
  logic [7:0]           r_err_count;

  logic [NUM_SLAVES-1:0] w_match;
  logic [NUM_SLAVES-1:0] w_sel_oh;
  logic [7:0]            w_rdata_arr [NUM_SLAVES];
  logic                  w_hit;
  logic [c_idx_w-1:0]    w_hit_idx;
  logic                  w_sel;
  logic [c_idx_w-1:0]    w_sel_idx;
  logic                  w_sel_valid;
  logic [7:0]            w_sel_rdata;
  logic [NUM_SLAVES-1:0] w_oe;
  logic                  w_ready;
  logic [7:0]            w_data;
  logic                  w_err_ev;
  logic                  w_err_tmo;
  logic [15:0]           w_err_addr;

  generate
    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_match
      assign w_match[g]     = ((cpu_address & SLAVE_MASK[16*g +: 16]) == SLAVE_BASE[16*g +: 16]);
      assign w_rdata_arr[g] = slave_rdata[8*g +: 8];
      assign w_sel_oh[g]    = w_sel && (w_sel_idx == c_idx_w'(g));
    end
  endgenerate

  // Descending scan so the lowest matching index is the last one written.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit     = 1'b1;
        w_hit_idx = c_idx_w'(i);
      end
    end
  end

  assign w_sel       = w_hit | DEFAULT_EN;
  assign w_sel_idx   = w_hit ? w_hit_idx : c_def_idx;
  assign w_sel_valid = slave_valid[w_sel_idx];
  assign w_sel_rdata = w_rdata_arr[w_sel_idx];

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_addr_nxt  = r_addr_q;
    w_oe        = w_sel_oh;
    w_ready     = 1'b0;
    w_data      = w_sel ? w_sel_rdata : FILL_BYTE;
    w_err_ev    = 1'b0;
    w_err_tmo   = 1'b0;
    w_err_addr  = cpu_address;
    case (r_state)
      ST_IDLE: begin
        if (!w_sel) begin
          w_ready  = 1'b1;
          w_err_ev = 1'b1;
        end else if (w_sel_valid) begin
          w_ready = 1'b1;
        end else begin
          w_state_nxt = ST_WAIT;
          w_wcnt_nxt  = 16'd1;
          w_addr_nxt  = cpu_address;
        end
      end
      ST_WAIT: begin
        // An address change while stalled means the CPU abandoned the access.
        if (cpu_address != r_addr_q) begin
          w_state_nxt = ST_IDLE;
          w_wcnt_nxt  = 16'd0;
        end else if (w_sel_valid) begin
          w_ready     = 1'b1;
          w_state_nxt = ST_IDLE;
          w_wcnt_nxt  = 16'd0;
        end else if (c_tmo_en && (r_wcnt == c_tmo)) begin
          w_state_nxt = ST_FORCE;
          w_wcnt_nxt  = 16'd0;
        end else begin
          w_wcnt_nxt = r_wcnt + 16'd1;
        end
      end
      ST_FORCE: begin
        // Strobes dropped so a slow slave cannot commit a write after release.
        w_oe        = '0;
        w_ready     = 1'b1;
        w_data      = FILL_BYTE;
        w_err_ev    = 1'b1;
        w_err_tmo   = 1'b1;
        w_err_addr  = r_addr_q;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_wcnt_nxt  = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state  <= ST_IDLE;
      r_wcnt   <= 16'd0;
      r_addr_q <= 16'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_wcnt   <= w_wcnt_nxt;
      r_addr_q <= w_addr_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_bus_err        <= 1'b0;
      r_err_address    <= 16'd0;
      r_err_is_timeout <= 1'b0;
      r_err_count      <= 8'd0;
    end else if (err_clear) begin
      r_bus_err   <= 1'b0;
      r_err_count <= 8'd0;
    end else if (w_err_ev) begin
      if (!r_bus_err) begin
        r_bus_err        <= 1'b1;
        r_err_address    <= w_err_addr;
        r_err_is_timeout <= w_err_tmo;
      end
      if (r_err_count != 8'hFF) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign cpu_ready      = w_ready & reset_l;
  assign cpu_data_in    = w_data;
  assign slave_oe       = w_oe;
  assign slave_wr       = w_oe & {NUM_SLAVES{cpu_write}};
  assign bus_err        = r_bus_err;
  assign err_address    = r_err_address;
  assign err_is_timeout = r_err_is_timeout;
  assign err_count      = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_pif_bus_fabric.sv
`default_nettype none
// ============================================================================
// Module      : tb_pif_bus_fabric
// Description : Two fabric configurations driven in parallel and compared
//               every cycle against an access-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pif_bus_fabric;

  localparam int NS = 4;

  logic            clk = 1'b0;
  logic            reset_l = 1'b1;
  logic [15:0]     cpu_address;
  logic            cpu_write;
  logic [NS-1:0]   slave_valid;
  logic [NS*8-1:0] slave_rdata;
  logic            err_clear;

  logic [7:0]      data_o  [2];
  logic            ready_o [2];
  logic [NS-1:0]   oe_o    [2];
  logic [NS-1:0]   wr_o    [2];
  logic            berr_o  [2];
  logic [15:0]     eaddr_o [2];
  logic            etmo_o  [2];
  logic [7:0]      ecnt_o  [2];

  always #5 clk = ~clk;

  // Window table: s0 0000-01FF, s1 C000-FFFF, s2 0280-02FF, s3 8000-FFFF (s1 wins the overlap)
  logic [15:0] t_base [NS] = '{16'h0000, 16'hC000, 16'h0280, 16'h8000};
  logic [15:0] t_mask [NS] = '{16'hFE00, 16'hC000, 16'hFF80, 16'h8000};
  int          t_def_en  [2] = '{0, 1};
  int          t_def_slv [2] = '{0, 3};
  int          t_tmo     [2] = '{4, 0};
  logic [7:0]  t_fill    [2] = '{8'hFF, 8'hA5};

  pif_bus_fabric #(
    .NUM_SLAVES(NS), .SLAVE_BASE(64'h8000_0280_C000_0000), .SLAVE_MASK(64'h8000_FF80_C000_FE00),
    .DEFAULT_EN(1'b0), .DEFAULT_SLAVE(0), .TIMEOUT_CYCLES(4), .FILL_BYTE(8'hFF)
  ) dut0 (
    .clk(clk), .reset_l(reset_l), .cpu_address(cpu_address), .cpu_write(cpu_write),
    .cpu_data_in(data_o[0]), .cpu_ready(ready_o[0]), .slave_oe(oe_o[0]), .slave_wr(wr_o[0]),
    .slave_valid(slave_valid), .slave_rdata(slave_rdata), .err_clear(err_clear),
    .bus_err(berr_o[0]), .err_address(eaddr_o[0]), .err_is_timeout(etmo_o[0]), .err_count(ecnt_o[0])
  );

  pif_bus_fabric #(
    .NUM_SLAVES(NS), .SLAVE_BASE(64'h8000_0280_C000_0000), .SLAVE_MASK(64'h8000_FF80_C000_FE00),
    .DEFAULT_EN(1'b1), .DEFAULT_SLAVE(3), .TIMEOUT_CYCLES(0), .FILL_BYTE(8'hA5)
  ) dut1 (
    .clk(clk), .reset_l(reset_l), .cpu_address(cpu_address), .cpu_write(cpu_write),
    .cpu_data_in(data_o[1]), .cpu_ready(ready_o[1]), .slave_oe(oe_o[1]), .slave_wr(wr_o[1]),
    .slave_valid(slave_valid), .slave_rdata(slave_rdata), .err_clear(err_clear),
    .bus_err(berr_o[1]), .err_address(eaddr_o[1]), .err_is_timeout(etmo_o[1]), .err_count(ecnt_o[1])
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: one outstanding access per configuration
  bit          m_pend  [2];
  logic [15:0] m_pa    [2];
  int          m_n     [2];
  bit          m_force [2];
  bit          m_berr  [2];
  logic [15:0] m_ea    [2];
  bit          m_et    [2];
  int          m_cnt   [2];

  function automatic int decode(input logic [15:0] a, input int k);
    int r = -1;
    for (int i = 0; i < NS; i++)
      if (r < 0 && ((a & t_mask[i]) == t_base[i])) r = i;
    if (r < 0 && t_def_en[k] == 1) r = t_def_slv[k];
    return r;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_mis++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", nm, k, obs, want);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 0; m_pa[k] = '0; m_n[k] = 0; m_force[k] = 0;
      m_berr[k] = 0; m_ea[k] = '0; m_et[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int            s;
      logic [NS-1:0] one;
      logic [NS-1:0] e_oe;
      logic [7:0]    e_data;
      logic          e_rdy;
      s   = decode(cpu_address, k);
      one = 1;
      if (m_force[k]) begin
        e_oe = '0; e_rdy = 1'b1; e_data = t_fill[k];
      end else begin
        e_oe   = (s >= 0) ? (one << s) : '0;
        e_data = (s >= 0) ? slave_rdata[8*s +: 8] : t_fill[k];
        if (m_pend[k] && cpu_address != m_pa[k]) e_rdy = 1'b0;
        else if (s < 0)                          e_rdy = 1'b1;
        else                                     e_rdy = slave_valid[s];
      end
      if (!reset_l) e_rdy = 1'b0;
      chk("oe",   k, oe_o[k],    e_oe);
      chk("wr",   k, wr_o[k],    cpu_write ? e_oe : '0);
      chk("rdy",  k, ready_o[k], e_rdy);
      chk("data", k, data_o[k],  e_data);
      chk("berr", k, berr_o[k],  m_berr[k]);
      chk("ecnt", k, ecnt_o[k],  m_cnt[k]);
      if (m_berr[k]) begin
        chk("eaddr", k, eaddr_o[k], m_ea[k]);
        chk("etmo",  k, etmo_o[k],  m_et[k]);
      end
    end
  endtask

  task automatic model_clock();
    if (!reset_l) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        int          s;
        bit          ev;
        bit          et;
        logic [15:0] ea;
        s = decode(cpu_address, k); ev = 0; et = 0; ea = cpu_address;
        if (m_force[k]) begin
          ev = 1; et = 1; ea = m_pa[k]; m_force[k] = 0; m_pend[k] = 0;
        end else if (m_pend[k] && cpu_address != m_pa[k]) begin
          m_pend[k] = 0;
        end else if (s < 0) begin
          ev = 1;
        end else if (slave_valid[s]) begin
          m_pend[k] = 0;
        end else if (!m_pend[k]) begin
          m_pend[k] = 1; m_pa[k] = cpu_address; m_n[k] = 1;
        end else if (t_tmo[k] != 0 && m_n[k] == t_tmo[k]) begin
          m_force[k] = 1; m_pend[k] = 0;
        end else begin
          m_n[k]++;
        end
        if (err_clear) begin
          m_berr[k] = 0; m_cnt[k] = 0;
        end else if (ev) begin
          if (!m_berr[k]) begin m_berr[k] = 1; m_ea[k] = ea; m_et[k] = et; end
          if (m_cnt[k] < 255) m_cnt[k]++;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic w, input logic [NS-1:0] v, input logic clr);
    cpu_address = a; cpu_write = w; slave_valid = v; err_clear = clr;
  endtask

  initial begin
    int hold;
    cpu_address = '0; cpu_write = 0; slave_valid = '0; slave_rdata = '0; err_clear = 0;
    model_reset();
    #1 reset_l = 1'b0;
    @(negedge clk);
    check_all();
    @(posedge clk); #1;
    reset_l = 1'b1;

    // zero-latency read
    slave_rdata = 32'h3322_115A;
    drive(16'h0105, 1'b0, 4'b0001, 1'b0); step();
    chk("t_read_data", 0, data_o[0], 8'h5A);

    // write with three wait states
    drive(16'h02A3, 1'b1, 4'b0000, 1'b0);
    repeat (3) step();
    slave_valid = 4'b0100; step();
    chk("t_wait_noerr", 0, berr_o[0], 1'b0);

    // watchdog timeout on slave3 window
    drive(16'h8010, 1'b0, 4'b0000, 1'b0);
    repeat (6) step();
    chk("t_tmo_cnt",  0, ecnt_o[0],  8'd1);
    chk("t_tmo_type", 0, etmo_o[0],  1'b1);
    chk("t_tmo_addr", 0, eaddr_o[0], 16'h8010);

    // clear, then two unmapped accesses
    drive(16'h0105, 1'b0, 4'b1111, 1'b1); step();
    drive(16'h0300, 1'b0, 4'b1000, 1'b0); step();
    cpu_address = 16'h0400; step();
    chk("t_unm_addr", 0, eaddr_o[0], 16'h0300);
    chk("t_unm_cnt",  0, ecnt_o[0],  8'd2);
    chk("t_unm_type", 0, etmo_o[0],  1'b0);

    // clear coincident with the forced completion
    drive(16'h8010, 1'b0, 4'b0000, 1'b0);
    repeat (5) step();
    err_clear = 1'b1; step();
    err_clear = 1'b0;
    chk("t_clr_berr", 0, berr_o[0], 1'b0);
    chk("t_clr_cnt",  0, ecnt_o[0], 8'd0);

    // saturating error counter
    drive(16'h0300, 1'b0, 4'b1000, 1'b0);
    repeat (260) step();
    chk("t_sat_cnt", 0, ecnt_o[0], 8'hFF);

    // asynchronous reset in the middle of a wait
    drive(16'h8010, 1'b0, 4'b0000, 1'b0);
    repeat (2) step();
    @(negedge clk); #2;
    reset_l = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t_rst_cnt", 0, ecnt_o[0], 8'd0);
    @(posedge clk); #1;
    reset_l = 1'b1;
    repeat (6) step();

    // randomized traffic; address held while an access is outstanding, up to a bound
    hold = 0;
    for (int it = 0; it < 600; it++) begin
      if (!(m_pend[0] || m_pend[1] || m_force[0] || m_force[1]) || hold >= 8) begin
        case ($urandom % 4)
          0:       cpu_address = 16'($urandom);
          1:       cpu_address = 16'($urandom % 512);
          2:       cpu_address = 16'h0200 + 16'($urandom % 256);
          default: cpu_address = 16'h8000 | 16'($urandom);
        endcase
        hold = 0;
      end else begin
        hold++;
      end
      cpu_write   = 1'($urandom);
      slave_valid = (($urandom % 4) == 0) ? '0 : NS'($urandom);
      slave_rdata = 32'($urandom);
      err_clear   = (($urandom % 16) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pif_bus_fabric.md
Name: pif_bus_fabric

Overview:
- Parametrised successor to the PIF top-level chip-select/read-mux/ready-mux logic on the 6502 bus.
- Decodes cpu_address against NUM_SLAVES base/mask windows and drives one-hot oe/wr strobes.
- Muxes read data and ready from the selected slave.
- Adds a per-access wait-state timeout watchdog, unmapped-access handling and error capture, so a hung slave can no longer stall the 6502 indefinitely.

Parameters:
- NUM_SLAVES, 8, number of slave channels (1..16).
- SLAVE_BASE, {16'h0000,...}, packed NUM_SLAVES*16 bits; slave i base in bits [16i+15:16i].
- SLAVE_MASK, {16'hFE00,...}, packed NUM_SLAVES*16 bits; slave i matches when (addr & mask_i) == base_i.
- DEFAULT_EN, 1; 1 routes unmapped addresses to DEFAULT_SLAVE, 0 treats them as bus errors.
- DEFAULT_SLAVE, 7, slave index used for unmapped accesses when DEFAULT_EN=1.
- TIMEOUT_CYCLES, 255, wait cycles before forced completion (1..65535); 0 disables the watchdog.
- FILL_BYTE, 8'hFF, read data returned on timeout or unmapped error.

Ports:
- clk  in  1  system clock
- reset_l  in  1  asynchronous active-low reset
- cpu_address  in  16  6502 address bus
- cpu_write  in  1  6502 write enable
- cpu_data_in  out  8  read data to the 6502
- cpu_ready  out  1  6502 RDY
- slave_oe  out  NUM_SLAVES  one-hot select
- slave_wr  out  NUM_SLAVES  one-hot write strobe (slave_oe & cpu_write)
- slave_valid  in  NUM_SLAVES  per-slave access-complete
- slave_rdata  in  NUM_SLAVES*8  packed read data, slave i in [8i+7:8i]
- err_clear  in  1  clears bus_err and err_count
- bus_err  out  1  sticky error flag
- err_address  out  16  address of the first error since the last clear
- err_is_timeout  out  1  1 = timeout, 0 = unmapped
- err_count  out  8  saturating error count

Behaviour:
Decode:
- Combinational, same cycle. The lowest matching index wins.
- No match: goes to DEFAULT_SLAVE if DEFAULT_EN=1; otherwise sel is none.

State machine (registered): IDLE, WAIT, FORCE.
- IDLE: a selected slave with valid=1 gives cpu_ready=1 and cpu_data_in = that slave's rdata, combinationally (zero added latency).
- IDLE: a selected slave with valid=0 goes to WAIT, wcnt <= 1, and latches addr_q = cpu_address.
- WAIT: valid=1 gives ready=1 and returns to IDLE. Otherwise wcnt increments.
- WAIT: when wcnt == TIMEOUT_CYCLES, go to FORCE.
- WAIT: if cpu_address != addr_q (RDY violation), go to IDLE and clear wcnt. No error is logged.
- FORCE: lasts exactly one cycle. cpu_ready=1, cpu_data_in=FILL_BYTE, slave_oe/slave_wr all 0 (no late write commits). Logs a timeout error, then goes to IDLE.
- TIMEOUT_CYCLES=0: WAIT never exits except on valid or an address change.

Unmapped access (DEFAULT_EN=0, no match):
- slave_oe=0, cpu_ready=1, cpu_data_in=FILL_BYTE in the same cycle.
- Logs an unmapped error on that clock edge.
- If the address is held over several ready cycles, each cycle counts as one access.

Error logging:
- When bus_err=0: sets bus_err, captures err_address and err_is_timeout.
- When bus_err=1: address and type are held (first-error capture); only err_count increments, saturating at 8'hFF.
- err_clear has priority over a same-cycle error: registers clear and the new error is dropped.

cpu_data_in when no slave is selected and not in FORCE: FILL_BYTE.

Reset (async assert, registers only):
- State=IDLE, wcnt=0, addr_q=0, bus_err=0, err_address=0, err_is_timeout=0, err_count=0.
- During reset, combinational outputs follow decode, but cpu_ready is forced 0.
- Reset in WAIT/FORCE aborts the access with no error logged.

Test Plan:
- Default map, read 16'h0105 with slave0 valid=1, rdata=8'h5A -> slave_oe=8'b00000001, cpu_ready=1, cpu_data_in=8'h5A in the same cycle; bus_err=0.
- Write 16'h02A3 with slave2 valid low for 3 cycles, then high -> cpu_ready low 3 cycles, high on the 4th; slave_wr[2]=1 throughout; no error.
- TIMEOUT_CYCLES=4, slave never valid -> WAIT for 4 cycles, then 1 FORCE cycle with ready=1, data=8'hFF, oe=0; bus_err=1, err_is_timeout=1, err_address=accessed address, err_count=1.
- DEFAULT_EN=0, read an unmapped address 16'h0300 -> same-cycle ready=1, data=8'hFF, slave_oe=0; err_is_timeout=0. A second unmapped access to 16'h0400 -> err_address stays 16'h0300, err_count=2.
- err_clear asserted in the same cycle as a timeout -> bus_err=0, err_count=0 afterwards. 256+ errors without a clear -> err_count saturates at 8'hFF.
- reset_l low mid-WAIT -> state IDLE and wcnt=0 immediately (async); cpu_ready=0 while in reset; no error logged.
